axi_read_fifo: RTL and testbench

//  AXI4 read master with FIFO that fetches SIZE-limited input words for the bitstream wrapper.

---
 rtl/axi_read_fifo_if.sv | 38 +++
 rtl/axi_read_fifo.sv | 155 +++++++++++++++
 tb/tb_axi_read_fifo.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_read_fifo_if.sv
// Request/delivery handshake and AXI4 read channels of the read-FIFO master.
interface axi_read_fifo_if;
  logic [31:0] READ_ADDR;
  logic [15:0] READ_COUNT;
  logic        READ_REQ;
  logic        READ_BUSY;
  logic [31:0] READ_DATA;
  logic        READ_VALID;
  logic        READ_READY;
  logic        ERR;
  logic [31:0] M_ARADDR;
  logic [7:0]  M_ARLEN;
  logic [2:0]  M_ARSIZE;
  logic [1:0]  M_ARBURST;
  logic        M_ARVALID;
  logic        M_ARREADY;
  logic [31:0] M_RDATA;
  logic [1:0]  M_RRESP;
  logic        M_RLAST;
  logic        M_RVALID;
  logic        M_RREADY;

  // Design-side view: issues AR, accepts R, serves the wrapper
  modport master (
    input  READ_ADDR, READ_COUNT, READ_REQ, READ_READY,
    input  M_ARREADY, M_RDATA, M_RRESP, M_RLAST, M_RVALID,
    output READ_BUSY, READ_DATA, READ_VALID, ERR,
    output M_ARADDR, M_ARLEN, M_ARSIZE, M_ARBURST, M_ARVALID, M_RREADY
  );

  // Environment view: wrapper plus AXI slave
  modport slave (
    output READ_ADDR, READ_COUNT, READ_REQ, READ_READY,
    output M_ARREADY, M_RDATA, M_RRESP, M_RLAST, M_RVALID,
    input  READ_BUSY, READ_DATA, READ_VALID, ERR,
    input  M_ARADDR, M_ARLEN, M_ARSIZE, M_ARBURST, M_ARVALID, M_RREADY
  );
endinterface

// File: rtl/axi_read_fifo.sv
// AXI4 read master: splits one (address, count) request into credit-limited INCR
// bursts that never cross 4 KB, buffers returned beats in a FWFT FIFO.
module axi_read_fifo #(
  parameter int unsigned FIFO_DEPTH = 64,
  parameter int unsigned MAX_BURST  = 16
) (
  input logic             CLK,
  input logic             RST_X,
  axi_read_fifo_if.master bus
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CALC  = 2'd1;
  localparam logic [1:0] S_ADDR  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]    r_state, w_state_nx;
  logic [31:0]   r_addr;
  logic [15:0]   r_remain;
  logic [8:0]    r_len;
  logic [CW-1:0] r_out;
  logic [31:0]   r_mem [FIFO_DEPTH];
  logic [AW:0]   r_wptr, r_rptr;
  logic [7:0]    r_bq [FIFO_DEPTH];
  logic [AW:0]   r_bq_wptr, r_bq_rptr;
  logic [7:0]    r_bcnt;
  logic          r_err, r_arvalid, r_busy, r_rready;
  logic [31:0]   r_araddr;
  logic [7:0]    r_arlen;

  logic [CW-1:0] w_count;
  logic          w_empty, w_accept, w_ar_hs, w_r_hs, w_push, w_pop, w_exp_last, w_go;
  logic [10:0]   w_to4k;
  logic [16:0]   w_len, w_credit;

  assign w_count    = r_wptr - r_rptr;
  assign w_empty    = (w_count == CW'(0));
  assign w_accept   = (r_state == S_IDLE) && bus.READ_REQ;
  assign w_ar_hs    = r_arvalid && bus.M_ARREADY;
  assign w_r_hs     = r_rready && bus.M_RVALID;
  assign w_push     = w_r_hs && (r_out != CW'(0));
  assign w_pop      = !w_empty && bus.READ_READY;
  assign w_exp_last = (r_bcnt == r_bq[r_bq_rptr[AW-1:0]]);
  assign w_to4k     = 11'd1024 - {1'b0, r_addr[11:2]};
  assign w_credit   = 17'(FIFO_DEPTH) - 17'(w_count) - 17'(r_out);
  assign w_go       = (w_credit >= w_len);

  assign bus.READ_BUSY  = r_busy;
  assign bus.READ_VALID = !w_empty;
  assign bus.READ_DATA  = w_empty ? 32'd0 : r_mem[r_rptr[AW-1:0]];
  assign bus.ERR        = r_err;
  assign bus.M_ARADDR   = r_araddr;
  assign bus.M_ARLEN    = r_arlen;
  assign bus.M_ARSIZE   = 3'b010;
  assign bus.M_ARBURST  = 2'b01;
  assign bus.M_ARVALID  = r_arvalid;
  assign bus.M_RREADY   = r_rready;

  // Next burst length: min(remaining, MAX_BURST, words left in this 4 KB page)
  always_comb begin
    w_len = 17'(r_remain);
    if (w_len > 17'(MAX_BURST)) w_len = 17'(MAX_BURST);
    if (w_len > 17'(w_to4k))    w_len = 17'(w_to4k);
  end

  // State register
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) r_state <= S_IDLE;
    else        r_state <= w_state_nx;
  end

  // Next-state logic
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:  if (w_accept && (bus.READ_COUNT != 16'd0)) w_state_nx = S_CALC;
      S_CALC:  if (w_go) w_state_nx = S_ADDR;
      S_ADDR:  if (w_ar_hs) w_state_nx = (r_remain != 16'(r_len)) ? S_CALC : S_DRAIN;
      S_DRAIN: if ((r_out == CW'(0)) && w_empty) w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Request tracking, AR channel and status flags
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      r_addr    <= 32'd0;
      r_remain  <= 16'd0;
      r_len     <= 9'd0;
      r_arvalid <= 1'b0;
      r_araddr  <= 32'd0;
      r_arlen   <= 8'd0;
      r_err     <= 1'b0;
      r_busy    <= 1'b0;
      r_rready  <= 1'b0;
    end else begin
      r_busy   <= (w_state_nx != S_IDLE);
      r_rready <= (w_state_nx != S_IDLE);
      if (w_accept) begin
        r_addr   <= bus.READ_ADDR & ~32'h3;
        r_remain <= bus.READ_COUNT;
      end
      if ((r_state == S_CALC) && w_go) begin
        r_len     <= 9'(w_len);
        r_araddr  <= r_addr;
        r_arlen   <= 8'(w_len - 17'd1);
        r_arvalid <= 1'b1;
      end
      if (w_ar_hs) begin
        r_arvalid <= 1'b0;
        r_addr    <= r_addr + 32'({r_len, 2'b00});
        r_remain  <= r_remain - 16'(r_len);
      end
      if (w_accept) begin
        r_err <= 1'b0;
      end else if (w_r_hs && ((r_out == CW'(0)) || (bus.M_RRESP != 2'b00) ||
                              (bus.M_RLAST != w_exp_last))) begin
        r_err <= 1'b1;
      end
    end
  end

  // Outstanding beats, FIFO pointers and burst-boundary tracking
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      r_out     <= CW'(0);
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_bq_wptr <= '0;
      r_bq_rptr <= '0;
      r_bcnt    <= 8'd0;
    end else begin
      r_out <= r_out + (w_ar_hs ? CW'(r_len) : CW'(0)) - (w_push ? CW'(1) : CW'(0));
      if (w_push) r_wptr <= r_wptr + (AW+1)'(1);
      if (w_pop)  r_rptr <= r_rptr + (AW+1)'(1);
      if (w_ar_hs) r_bq_wptr <= r_bq_wptr + (AW+1)'(1);
      if (w_push) begin
        if (w_exp_last) begin
          r_bcnt    <= 8'd0;
          r_bq_rptr <= r_bq_rptr + (AW+1)'(1);
        end else begin
          r_bcnt <= r_bcnt + 8'd1;
        end
      end
    end
  end

  // Data FIFO and per-burst length queue storage
  always_ff @(posedge CLK) begin
    if (w_push)  r_mem[r_wptr[AW-1:0]]   <= bus.M_RDATA;
    if (w_ar_hs) r_bq[r_bq_wptr[AW-1:0]] <= r_arlen;
  end
endmodule

// File: tb/tb_axi_read_fifo.sv
// Bench for axi_read_fifo: random-timing AXI slave and consumer, with a
// burst-plan / word-stream model derived from the request alone.
module tb_axi_read_fifo;
  localparam int unsigned FIFO_DEPTH = 64;
  localparam int unsigned MAX_BURST  = 16;

  typedef struct packed {logic [31:0] addr; logic [7:0] len;} ar_t;
  typedef struct packed {logic [31:0] data; logic last;} beat_t;

  logic CLK = 1'b0;
  logic RST_X;
  always #5 CLK = ~CLK;

  axi_read_fifo_if bus();
  axi_read_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .MAX_BURST(MAX_BURST)) dut (
    .CLK(CLK), .RST_X(RST_X), .bus(bus));

  ar_t         exp_ar_q[$];
  logic [31:0] exp_w_q[$];
  beat_t       rq[$];

  int checks = 0, failures = 0;
  int ar_pct, r_pct, rd_pct, ar_limit, ar_cnt, issued, pops, occ, beat_no, err_beat, flip_beat;
  bit offering, exp_err, arv_wait;
  logic [31:0] off_data, prev_addr;
  logic        off_last, off_true_last;
  logic [1:0]  off_resp;
  logic [7:0]  prev_len;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  // Expected AR sequence and word stream straight from the splitting rules
  function automatic void plan(input logic [31:0] a, input int n);
    logic [31:0] cur;
    int rem, l, to4k;
    ar_t e;
    cur = {a[31:2], 2'b00};
    rem = n;
    for (int i = 0; i < n; i++) exp_w_q.push_back(mem_word(cur + 32'(4 * i)));
    while (rem > 0) begin
      to4k = (4096 - int'(cur[11:0])) / 4;
      l = rem;
      if (l > int'(MAX_BURST)) l = int'(MAX_BURST);
      if (l > to4k) l = to4k;
      e.addr = cur;
      e.len  = 8'(l - 1);
      exp_ar_q.push_back(e);
      cur = cur + 32'(4 * l);
      rem -= l;
    end
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One cycle: check flags, then drive the R slave, AR slave and consumer for the next edge
  task automatic tick();
    bit rdy;
    beat_t b;
    ar_t e;
    logic [31:0] w;
    @(negedge CLK);
    chk("err", bus.ERR, exp_err);
    chk("valid_vs_occ", bus.READ_VALID, occ != 0);
    if (!offering && rq.size() > 0 && $urandom_range(99, 0) < 32'(r_pct)) begin
      offering      = 1'b1;
      off_data      = rq[0].data;
      off_true_last = rq[0].last;
      off_last      = (beat_no == flip_beat) ? ~rq[0].last : rq[0].last;
      off_resp      = (beat_no == err_beat) ? 2'b10 : 2'b00;
    end
    bus.M_RVALID = offering;
    bus.M_RDATA  = offering ? off_data : 32'd0;
    bus.M_RLAST  = offering ? off_last : 1'b0;
    bus.M_RRESP  = offering ? off_resp : 2'b00;
    if (offering && bus.M_RREADY) begin
      b = rq.pop_front();
      if (off_resp != 2'b00 || off_last != off_true_last) exp_err = 1'b1;
      beat_no++;
      occ++;
      chk("occ_max", occ <= int'(FIFO_DEPTH), 1);
      offering = 1'b0;
    end
    bus.M_ARREADY = (ar_cnt < ar_limit) && ($urandom_range(99, 0) < 32'(ar_pct));
    if (arv_wait) begin
      chk("ar_hold_valid", bus.M_ARVALID, 1);
      chk("ar_hold_addr", bus.M_ARADDR, prev_addr);
      chk("ar_hold_len", bus.M_ARLEN, prev_len);
    end
    arv_wait = 1'b0;
    if (bus.M_ARVALID) begin
      if (bus.M_ARREADY) begin
        if (exp_ar_q.size() == 0) chk("ar_extra", bus.M_ARVALID, 0);
        else begin
          e = exp_ar_q.pop_front();
          chk("araddr", bus.M_ARADDR, e.addr);
          chk("arlen", bus.M_ARLEN, e.len);
        end
        for (int k = 0; k <= int'(bus.M_ARLEN); k++) begin
          b.data = mem_word(bus.M_ARADDR + 32'(4 * k));
          b.last = (k == int'(bus.M_ARLEN));
          rq.push_back(b);
        end
        ar_cnt++;
        issued += int'(bus.M_ARLEN) + 1;
        chk("credit", (issued - pops) <= int'(FIFO_DEPTH), 1);
      end else begin
        arv_wait  = 1'b1;
        prev_addr = bus.M_ARADDR;
        prev_len  = bus.M_ARLEN;
      end
    end
    rdy = ($urandom_range(99, 0) < 32'(rd_pct));
    bus.READ_READY = rdy;
    if (bus.READ_VALID && rdy) begin
      if (exp_w_q.size() == 0) chk("extra_word", bus.READ_VALID, 0);
      else begin
        w = exp_w_q.pop_front();
        chk("rdata", bus.READ_DATA, w);
      end
      pops++;
      occ--;
    end
  endtask

  task automatic start_req(input logic [31:0] a, input int n);
    plan(a, n);
    bus.READ_ADDR  = a;
    bus.READ_COUNT = 16'(n);
    bus.READ_REQ   = 1'b1;
    exp_err = 1'b0;
    ar_cnt  = 0;
    issued  = 0;
    pops    = 0;
    beat_no = 0;
    tick();
    bus.READ_REQ   = 1'b0;
    bus.READ_ADDR  = $urandom;
    bus.READ_COUNT = 16'($urandom);
    chk("busy_rise", bus.READ_BUSY, n != 0);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (exp_w_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk("words_pending", exp_w_q.size(), 0);
    tick();
    chk("busy_hold", bus.READ_BUSY, 1);
    tick();
    chk("busy_fall", bus.READ_BUSY, 0);
    chk("ar_pending", exp_ar_q.size(), 0);
  endtask

  task automatic set_pct(input int a, input int r, input int d);
    ar_pct = a;
    r_pct  = r;
    rd_pct = d;
  endtask

  initial begin
    int n;
    RST_X = 1'b1;
    bus.READ_ADDR = 32'd0; bus.READ_COUNT = 16'd0; bus.READ_REQ = 1'b0; bus.READ_READY = 1'b0;
    bus.M_ARREADY = 1'b0; bus.M_RDATA = 32'd0; bus.M_RRESP = 2'b00; bus.M_RLAST = 1'b0;
    bus.M_RVALID = 1'b0;
    set_pct(100, 100, 100);
    ar_limit = 1000; err_beat = -1; flip_beat = -1;
    occ = 0; offering = 1'b0; exp_err = 1'b0; arv_wait = 1'b0;
    ar_cnt = 0; issued = 0; pops = 0; beat_no = 0;
    #1 RST_X = 1'b0;
    #1;
    chk("rst_busy", bus.READ_BUSY, 0);
    chk("rst_valid", bus.READ_VALID, 0);
    chk("rst_data", bus.READ_DATA, 0);
    chk("rst_err", bus.ERR, 0);
    chk("rst_arvalid", bus.M_ARVALID, 0);
    chk("rst_rready", bus.M_RREADY, 0);
    chk("arsize", bus.M_ARSIZE, 3'b010);
    chk("arburst", bus.M_ARBURST, 2'b01);
    tick(); tick();
    RST_X = 1'b1;

    // Single 12-beat burst, always-ready handshakes
    start_req(32'h1000_0000, 12);
    wait_done(500);

    // 40 words -> 16/16/8; a request pulse while busy must be ignored
    start_req(32'h1000_0000, 40);
    bus.READ_ADDR = 32'h7777_0000; bus.READ_COUNT = 16'd5; bus.READ_REQ = 1'b1;
    tick();
    bus.READ_REQ = 1'b0;
    wait_done(1000);

    // 4 KB split
    start_req(32'h0000_0FF0, 8);
    wait_done(500);

    // Address wrap past 2^32 with an unaligned start
    start_req(32'hFFFF_FFF3, 8);
    wait_done(500);

    // Zero-count request is a no-op
    start_req(32'h4000_0000, 0);
    tick(); tick();
    chk("zero_arvalid", bus.M_ARVALID, 0);
    chk("zero_busy", bus.READ_BUSY, 0);

    // Consumer stalled: credit caps accepted beats at FIFO_DEPTH
    set_pct(100, 100, 0);
    start_req(32'h2000_0000, 200);
    repeat (150) tick();
    chk("stall_occ", occ, FIFO_DEPTH);
    chk("stall_issued", issued, FIFO_DEPTH);
    chk("stall_arvalid", bus.M_ARVALID, 0);
    rd_pct = 100;
    wait_done(3000);

    // Bad RRESP on the third beat: sticky ERR, data still delivered
    err_beat = 2;
    start_req(32'h5000_0000, 8);
    wait_done(500);
    chk("err_sticky", bus.ERR, 1);
    err_beat = -1;
    start_req(32'h5000_1000, 4);
    chk("err_cleared", bus.ERR, 0);
    wait_done(500);

    // RLAST missing on a burst's final beat
    flip_beat = 3;
    start_req(32'h5000_2000, 4);
    wait_done(500);
    chk("err_rlast", bus.ERR, 1);
    flip_beat = -1;

    // Randomized requests and handshake timing
    for (int r = 0; r < 6; r++) begin
      logic [31:0] a;
      a = $urandom;
      if (r % 2 == 0) a[11:0] = 12'hF00 | 12'($urandom_range(255, 0));
      set_pct(int'($urandom_range(100, 20)), int'($urandom_range(100, 20)),
              int'($urandom_range(100, 20)));
      start_req(a, int'($urandom_range(100, 1)));
      wait_done(4000);
    end

    // Reset mid-request: ARVALID pending with the FIFO half full
    set_pct(100, 100, 0);
    ar_limit = 2;
    start_req(32'h3000_0000, 200);
    n = 0;
    while (!(bus.M_ARVALID && occ == 32) && n < 300) begin
      tick();
      n++;
    end
    chk("rst_setup_arvalid", bus.M_ARVALID, 1);
    chk("rst_setup_occ", occ, 32);
    RST_X = 1'b0;
    #1;
    chk("mid_rst_arvalid", bus.M_ARVALID, 0);
    chk("mid_rst_busy", bus.READ_BUSY, 0);
    chk("mid_rst_valid", bus.READ_VALID, 0);
    chk("mid_rst_data", bus.READ_DATA, 0);
    chk("mid_rst_err", bus.ERR, 0);
    chk("mid_rst_rready", bus.M_RREADY, 0);
    chk("mid_rst_araddr", bus.M_ARADDR, 0);
    chk("mid_rst_arlen", bus.M_ARLEN, 0);
    exp_w_q.delete(); exp_ar_q.delete(); rq.delete();
    offering = 1'b0; arv_wait = 1'b0; exp_err = 1'b0; occ = 0;
    bus.M_RVALID = 1'b0; bus.M_ARREADY = 1'b0;
    ar_limit = 1000;
    rd_pct = 100;
    tick(); tick();
    RST_X = 1'b1;
    start_req(32'h3000_0100, 4);
    wait_done(500);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
